// File: rtl/act_pkg.sv
// Shared definitions for the activation serializer: FSM encoding and
// default lane geometry.
package act_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int default_data_size  = 16;
  localparam int default_array_size = 9;

endpackage

// File: rtl/act_relu.sv
// Combinational activation on one signed lane word. ACT_RELU_EN selects
// ReLU; otherwise the word passes through unchanged at full width.
module act_relu #(
  parameter int data_size = 16
) (
  input  logic [data_size-1:0] x,
  output logic [data_size-1:0] y
);

`ifdef ACT_RELU_EN
  assign y = x[data_size-1] ? '0 : x;
`else
  assign y = x;
`endif

endmodule

// File: rtl/act_serializer.sv
// Captures a complete vector of bias-added lanes and streams the activated
// words out one per accepted handshake. Activation chosen by ACT_RELU_EN.
module act_serializer
  import act_pkg::*;
#(
  parameter int data_size  = default_data_size,
  parameter int array_size = default_array_size
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [array_size-1:0]           lane_done,
  input  logic [array_size*data_size-1:0] lane_data,
  output logic                            in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [data_size-1:0]            out_data,
  output logic [$clog2(array_size)-1:0]   out_lane,
  output logic                            out_last,
  output logic                            frame_done
);

  localparam int lane_w = $clog2(array_size);
  localparam logic [lane_w-1:0] last_idx = lane_w'(array_size - 1);

  state_t              state_reg, state_next;
  logic [lane_w-1:0]   idx_reg, idx_next;
  logic                frame_done_reg, frame_done_next;
  logic                capture;
  logic [data_size-1:0] lane_word [array_size];
  logic [data_size-1:0] buffer_reg [array_size];
  logic [data_size-1:0] act_word;

  genvar gi;
  generate
    for (gi = 0; gi < array_size; gi++) begin : g_lane
      assign lane_word[gi] = lane_data[gi*data_size +: data_size];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      frame_done_reg <= frame_done_next;
    end
  end

  // Buffer only loads on the capture edge, so lane changes during SEND are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < array_size; i++) buffer_reg[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < array_size; i++) buffer_reg[i] <= lane_word[i];
    end
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    frame_done_next = 1'b0;
    capture         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (&lane_done) begin
          capture    = 1'b1;
          idx_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx_reg == last_idx) begin
            idx_next        = '0;
            state_next      = IDLE;
            frame_done_next = 1'b1;
          end else begin
            idx_next = idx_reg + lane_w'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  act_relu #(
    .data_size(data_size)
  ) u_act (
    .x(buffer_reg[idx_reg]),
    .y(act_word)
  );

  assign in_ready   = rst_n && (state_reg == IDLE);
  assign out_valid  = (state_reg == SEND);
  assign out_data   = act_word;
  assign out_lane   = idx_reg;
  assign out_last   = (idx_reg == last_idx);
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_act_serializer.sv
// Randomized and directed bench for act_serializer against a queue-based
// model of captured vectors.
module tb_act_serializer;

  localparam int DW = 16;
  localparam int AN = 9;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [AN-1:0]      lane_done = '0;
  logic [AN*DW-1:0]   lane_data = '0;
  logic               out_ready = 1'b0;
  logic               in_ready;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic [$clog2(AN)-1:0] out_lane;
  logic               out_last;
  logic               frame_done;

  act_serializer #(
    .data_size(DW),
    .array_size(AN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .lane_done(lane_done),
    .lane_data(lane_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_lane(out_lane),
    .out_last(out_last),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: words still owed for the current vector, oldest first.
  logic [DW-1:0] q[$];
  bit busy = 1'b0;
  bit fd_exp = 1'b0;

  function automatic logic [DW-1:0] act_ref(input logic [DW-1:0] x);
`ifdef ACT_RELU_EN
    if ($signed(x) < 0) return '0;
    return x;
`else
    return x;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; model decides from the inputs present before the edge.
  task automatic step();
    bit fd_n = 1'b0;
    if (!rst_n) begin
      q.delete();
      busy = 1'b0;
    end else if (!busy) begin
      if (&lane_done) begin
        for (int i = 0; i < AN; i++) q.push_back(act_ref(lane_data[i*DW +: DW]));
        busy = 1'b1;
        $display("capture lanes=%0h", lane_data);
      end
    end else if (out_ready) begin
      $display("xfer lane=%0d data=%0h", AN - q.size(), q[0]);
      void'(q.pop_front());
      if (q.size() == 0) begin
        busy = 1'b0;
        fd_n = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    fd_exp = fd_n;
    check("in_ready", {31'b0, in_ready}, {31'b0, rst_n && !busy});
    check("out_valid", {31'b0, out_valid}, {31'b0, busy});
    check("frame_done", {31'b0, frame_done}, {31'b0, fd_exp});
    if (busy) begin
      check("out_data", {16'b0, out_data}, {16'b0, q[0]});
      check("out_lane", {28'b0, out_lane}, AN - q.size());
      check("out_last", {31'b0, out_last}, {31'b0, q.size() == 1});
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset: outputs cleared, in_ready forced low.
    rst_n = 1'b0;
    run(3);
    check("rst_out_data", {16'b0, out_data}, 32'h0);
    check("rst_out_lane", {28'b0, out_lane}, 32'h0);
    check("rst_out_last", {31'b0, out_last}, 32'h0);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_rst", {31'b0, in_ready}, 32'h1);

    // Lanes 1..9 with out_ready held high.
    for (int i = 0; i < AN; i++) lane_data[i*DW +: DW] = DW'(i + 1);
    out_ready = 1'b1;
    lane_done = '1;
    step();
    lane_done = '0;
    run(11);

    // Partial vector for 5 cycles, then complete.
    lane_done = 9'h0FF;
    run(5);
    lane_done = 9'h1FF;
    step();
    lane_done = '0;
    run(11);

    // Negative and positive words through the activation.
    for (int i = 0; i < AN; i++) lane_data[i*DW +: DW] = (i % 2 == 0) ? 16'hFFF6 : 16'h0005;
    lane_done = '1;
    step();
    lane_done = '0;
    run(11);

    // Stall 3 cycles at lane 4; change lane_data while sending.
    for (int i = 0; i < AN; i++) lane_data[i*DW +: DW] = DW'($urandom);
    lane_done = '1;
    step();
    lane_done = '1;
    run(4);
    for (int i = 0; i < AN; i++) lane_data[i*DW +: DW] = DW'($urandom);
    out_ready = 1'b0;
    run(3);
    check("stall_lane", {28'b0, out_lane}, 32'd4);
    out_ready = 1'b1;
    lane_done = '0;
    run(7);

    // Reset pulsed while lane 3 is on the output.
    lane_done = '1;
    step();
    lane_done = '0;
    run(3);
    check("pre_rst_lane", {28'b0, out_lane}, 32'd3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("in_ready_mid_rst", {31'b0, in_ready}, 32'h1);
    run(3);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < AN; i++) lane_data[i*DW +: DW] = DW'($urandom);
      lane_done = ($urandom_range(0, 2) == 0) ? AN'($urandom) : '1;
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
